// File: rtl/bellek_hakemi_pkg.sv
// Shared encodings and default widths for the shared memory-port arbiter.
package bellek_hakemi_pkg;

    localparam int ADRES_W_VARSAYILAN     = 32;
    localparam int VERI_W_VARSAYILAN      = 32;
    localparam int MAX_ARDISIK_VARSAYILAN = 4;
    localparam int SAYAC_W                = 4;

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISTEK = 2'd1;
    localparam logic [1:0] BEKLE = 2'd2;

    localparam logic SAHIP_GETIR = 1'b0;
    localparam logic SAHIP_VB    = 1'b1;

    typedef struct packed {
        logic getir;
        logic vb;
    } izin_t;

endpackage

// File: rtl/bellek_hakemi_oncelik.sv
// Two-way priority arbiter: load/store is favoured, but fetch wins after
// MAX_ARDISIK consecutive load/store grants taken while it was waiting.
module bellek_hakemi_oncelik
    import bellek_hakemi_pkg::*;
#(
    parameter int MAX_ARDISIK = MAX_ARDISIK_VARSAYILAN
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  getir_istek,
    input  logic  getir_iptal,
    input  logic  vb_istek,
    input  logic  izin_acik,
    output izin_t izin
);

    localparam logic [SAYAC_W-1:0] MAX_L = SAYAC_W'(MAX_ARDISIK);

    logic [SAYAC_W-1:0] sayac;
    logic               getir_aday;
    logic               aclik;

    assign getir_aday = getir_istek && !getir_iptal;
    assign aclik      = (sayac == MAX_L);

    always_comb begin
        // NOTE: default every output first so no path through the block infers a latch.
        izin = '0;
        if (izin_acik) begin
            if (getir_aday && (!vb_istek || aclik)) begin
                izin.getir = 1'b1;
            end else if (vb_istek) begin
                izin.vb = 1'b1;
            end
        end
    end

    // Saturates at MAX_L so a flushed fetch cannot push the counter past the compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_ni) begin
            sayac <= '0;
        end else if (izin_acik) begin
            if (izin.getir || !getir_istek) begin
                sayac <= '0;
            end else if (izin.vb && !aclik) begin
                sayac <= sayac + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bellek_hakemi.sv
// Shares one memory port between fetch and load/store with a single
// outstanding request/accept/response transaction and fetch flush support.
module bellek_hakemi
    import bellek_hakemi_pkg::*;
#(
    parameter int ADRES_W     = ADRES_W_VARSAYILAN,
    parameter int VERI_W      = VERI_W_VARSAYILAN,
    parameter int MAX_ARDISIK = MAX_ARDISIK_VARSAYILAN
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               getir_istek_i,
    input  logic [ADRES_W-1:0] getir_ps_i,
    input  logic               getir_iptal_i,
    output logic               getir_gecerli_o,
    output logic [VERI_W-1:0]  getir_deger_o,
    input  logic               vb_istek_i,
    input  logic [ADRES_W-1:0] vb_adres_i,
    input  logic               vb_yaz_i,
    input  logic [VERI_W-1:0]  vb_veri_i,
    input  logic [3:0]         vb_maske_i,
    output logic               vb_gecerli_o,
    output logic [VERI_W-1:0]  vb_veri_o,
    output logic               mem_istek_o,
    output logic [ADRES_W-1:0] mem_adres_o,
    output logic               mem_yaz_o,
    output logic [VERI_W-1:0]  mem_veri_o,
    output logic [3:0]         mem_maske_o,
    input  logic               mem_kabul_i,
    input  logic               mem_gecerli_i,
    input  logic [VERI_W-1:0]  mem_veri_i,
    output logic               hata_o
);

    logic [1:0] durum;
    logic       sahip;
    logic       iptal_bit;
    logic       yanit;
    izin_t      izin;

    bellek_hakemi_oncelik #(
        .MAX_ARDISIK (MAX_ARDISIK)
    ) u_oncelik (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .getir_istek (getir_istek_i),
        .getir_iptal (getir_iptal_i),
        .vb_istek    (vb_istek_i),
        .izin_acik   (durum == BOSTA),
        .izin        (izin)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum       <= BOSTA;
            sahip       <= SAHIP_GETIR;
            iptal_bit   <= 1'b0;
            hata_o      <= 1'b0;
            mem_istek_o <= 1'b0;
            mem_adres_o <= '0;
            mem_yaz_o   <= 1'b0;
            mem_veri_o  <= '0;
            mem_maske_o <= 4'b0000;
        end else begin
            if (mem_gecerli_i && (durum != BEKLE)) begin
                hata_o <= 1'b1;
            end
            case (durum)
                BOSTA: begin
                    if (izin.getir) begin
                        durum       <= ISTEK;
                        sahip       <= SAHIP_GETIR;
                        mem_istek_o <= 1'b1;
                        mem_adres_o <= getir_ps_i;
                        mem_yaz_o   <= 1'b0;
                        mem_veri_o  <= '0;
                        mem_maske_o <= 4'b0000;
                    end else if (izin.vb) begin
                        durum       <= ISTEK;
                        sahip       <= SAHIP_VB;
                        mem_istek_o <= 1'b1;
                        mem_adres_o <= vb_adres_i;
                        mem_yaz_o   <= vb_yaz_i;
                        mem_veri_o  <= vb_yaz_i ? vb_veri_i : '0;
                        mem_maske_o <= vb_yaz_i ? vb_maske_i : 4'b0000;
                    end
                end
                ISTEK: begin
                    // An accept in the same cycle as a flush still commits the transaction.
                    if (mem_kabul_i) begin
                        durum       <= BEKLE;
                        mem_istek_o <= 1'b0;
                        if (sahip == SAHIP_GETIR && getir_iptal_i) begin
                            iptal_bit <= 1'b1;
                        end
                    end else if (sahip == SAHIP_GETIR && getir_iptal_i) begin
                        durum       <= BOSTA;
                        mem_istek_o <= 1'b0;
                    end
                end
                BEKLE: begin
                    if (mem_gecerli_i) begin
                        durum     <= BOSTA;
                        iptal_bit <= 1'b0;
                    end else if (sahip == SAHIP_GETIR && getir_iptal_i) begin
                        iptal_bit <= 1'b1;
                    end
                end
                default: begin
                    durum       <= BOSTA;
                    mem_istek_o <= 1'b0;
                end
            endcase
        end
    end

    assign yanit           = (durum == BEKLE) && mem_gecerli_i;
    assign getir_gecerli_o = yanit && (sahip == SAHIP_GETIR) && !iptal_bit;
    assign vb_gecerli_o    = yanit && (sahip == SAHIP_VB);
    assign getir_deger_o   = mem_veri_i;
    assign vb_veri_o       = mem_veri_i;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi: handshake, routing, starvation, flush, errors.
module tb_bellek_hakemi;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        getir_istek_i, getir_iptal_i;
    logic [31:0] getir_ps_i;
    logic        getir_gecerli_o;
    logic [31:0] getir_deger_o;
    logic        vb_istek_i, vb_yaz_i;
    logic [31:0] vb_adres_i, vb_veri_i;
    logic [3:0]  vb_maske_i;
    logic        vb_gecerli_o;
    logic [31:0] vb_veri_o;
    logic        mem_istek_o, mem_yaz_o;
    logic [31:0] mem_adres_o, mem_veri_o;
    logic [3:0]  mem_maske_o;
    logic        mem_kabul_i, mem_gecerli_i;
    logic [31:0] mem_veri_i;
    logic        hata_o;

    int toplam = 0;
    int gecen  = 0;

    bellek_hakemi #(.ADRES_W(32), .VERI_W(32), .MAX_ARDISIK(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .getir_istek_i(getir_istek_i), .getir_ps_i(getir_ps_i), .getir_iptal_i(getir_iptal_i),
        .getir_gecerli_o(getir_gecerli_o), .getir_deger_o(getir_deger_o),
        .vb_istek_i(vb_istek_i), .vb_adres_i(vb_adres_i), .vb_yaz_i(vb_yaz_i),
        .vb_veri_i(vb_veri_i), .vb_maske_i(vb_maske_i),
        .vb_gecerli_o(vb_gecerli_o), .vb_veri_o(vb_veri_o),
        .mem_istek_o(mem_istek_o), .mem_adres_o(mem_adres_o), .mem_yaz_o(mem_yaz_o),
        .mem_veri_o(mem_veri_o), .mem_maske_o(mem_maske_o),
        .mem_kabul_i(mem_kabul_i), .mem_gecerli_i(mem_gecerli_i), .mem_veri_i(mem_veri_i),
        .hata_o(hata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        getir_istek_i = 0; getir_iptal_i = 0; getir_ps_i = '0;
        vb_istek_i = 0; vb_yaz_i = 0; vb_adres_i = '0; vb_veri_i = '0; vb_maske_i = '0;
        mem_kabul_i = 0; mem_gecerli_i = 0; mem_veri_i = '0;
        #12;
        toplam++; if ({mem_istek_o, mem_yaz_o, mem_maske_o} !== 6'b0) $display("FAIL reset_ctrl got=%b want=0", {mem_istek_o, mem_yaz_o, mem_maske_o}); else gecen++;
        toplam++; if ({mem_adres_o, mem_veri_o} !== 64'h0) $display("FAIL reset_data got=%h want=0", {mem_adres_o, mem_veri_o}); else gecen++;
        toplam++; if ({hata_o, getir_gecerli_o, vb_gecerli_o} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {hata_o, getir_gecerli_o, vb_gecerli_o}); else gecen++;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        getir_istek_i = 1; getir_ps_i = 32'h100;
        tick();
        toplam++; if (mem_istek_o !== 1'b1) $display("FAIL fetch_istek got=%b want=1", mem_istek_o); else gecen++;
        toplam++; if (mem_adres_o !== 32'h100) $display("FAIL fetch_adres got=%h want=00000100", mem_adres_o); else gecen++;
        toplam++; if ({mem_yaz_o, mem_maske_o} !== 5'b0) $display("FAIL fetch_yaz_maske got=%b want=0", {mem_yaz_o, mem_maske_o}); else gecen++;
        mem_kabul_i = 1;
        tick();
        mem_kabul_i = 0;
        toplam++; if (mem_istek_o !== 1'b0) $display("FAIL fetch_istek_drop got=%b want=0", mem_istek_o); else gecen++;
        mem_gecerli_i = 1; mem_veri_i = 32'h00000013;
        #1;
        toplam++; if ({getir_gecerli_o, vb_gecerli_o} !== 2'b10) $display("FAIL fetch_valid got=%b want=10", {getir_gecerli_o, vb_gecerli_o}); else gecen++;
        toplam++; if (getir_deger_o !== 32'h00000013) $display("FAIL fetch_deger got=%h want=00000013", getir_deger_o); else gecen++;
        tick();
        mem_gecerli_i = 0; getir_istek_i = 0;
        tick();
    endtask

    task automatic test_store();
        vb_istek_i = 1; vb_yaz_i = 1; vb_adres_i = 32'h2000; vb_veri_i = 32'hDEADBEEF; vb_maske_i = 4'b0011;
        tick();
        toplam++; if ({mem_istek_o, mem_yaz_o} !== 2'b11) $display("FAIL store_ctrl got=%b want=11", {mem_istek_o, mem_yaz_o}); else gecen++;
        toplam++; if (mem_adres_o !== 32'h2000 || mem_veri_o !== 32'hDEADBEEF) $display("FAIL store_data got=%h/%h want=00002000/deadbeef", mem_adres_o, mem_veri_o); else gecen++;
        toplam++; if (mem_maske_o !== 4'b0011) $display("FAIL store_maske got=%b want=0011", mem_maske_o); else gecen++;
        mem_kabul_i = 1;
        tick();
        mem_kabul_i = 0; mem_gecerli_i = 1; mem_veri_i = 32'h0;
        #1;
        toplam++; if ({getir_gecerli_o, vb_gecerli_o} !== 2'b01) $display("FAIL store_ack got=%b want=01", {getir_gecerli_o, vb_gecerli_o}); else gecen++;
        tick();
        mem_gecerli_i = 0; vb_istek_i = 0; vb_yaz_i = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit          vb_sira [7] = '{1, 1, 1, 1, 0, 1, 1};
        logic [31:0] bek_adres;
        getir_istek_i = 1; getir_ps_i = 32'h400;
        vb_istek_i = 1; vb_yaz_i = 0; vb_adres_i = 32'h800; vb_veri_i = 32'h55; vb_maske_i = 4'hF;
        for (int i = 0; i < 7; i++) begin
            toplam++; if (mem_istek_o !== 1'b0) $display("FAIL b2b_idle[%0d] got=%b want=0", i, mem_istek_o); else gecen++;
            tick();
            bek_adres = vb_sira[i] ? 32'h800 : 32'h400;
            toplam++; if (mem_adres_o !== bek_adres) $display("FAIL b2b_grant[%0d] got=%h want=%h", i, mem_adres_o, bek_adres); else gecen++;
            toplam++; if (mem_maske_o !== 4'b0000) $display("FAIL b2b_maske[%0d] got=%b want=0000", i, mem_maske_o); else gecen++;
            mem_kabul_i = 1;
            tick();
            mem_kabul_i = 0; mem_gecerli_i = 1; mem_veri_i = 32'hC0DE0000 + i;
            #1;
            toplam++; if ({getir_gecerli_o, vb_gecerli_o} !== {!vb_sira[i], vb_sira[i]}) $display("FAIL b2b_route[%0d] got=%b want=%b", i, {getir_gecerli_o, vb_gecerli_o}, {!vb_sira[i], vb_sira[i]}); else gecen++;
            tick();
            mem_gecerli_i = 0;
        end
        getir_istek_i = 0; vb_istek_i = 0;
        tick();
    endtask

    task automatic test_flush();
        // Withdraw while ISTEK with no accept.
        getir_istek_i = 1; getir_ps_i = 32'h300;
        tick();
        toplam++; if (mem_istek_o !== 1'b1) $display("FAIL flush_istek got=%b want=1", mem_istek_o); else gecen++;
        tick();
        getir_iptal_i = 1;
        tick();
        getir_iptal_i = 0; getir_istek_i = 0;
        toplam++; if (mem_istek_o !== 1'b0) $display("FAIL flush_withdraw got=%b want=0", mem_istek_o); else gecen++;
        tick();
        toplam++; if (mem_istek_o !== 1'b0) $display("FAIL flush_no_regrant got=%b want=0", mem_istek_o); else gecen++;
        // Flush during BEKLE: response dropped.
        getir_istek_i = 1; getir_ps_i = 32'h304;
        tick();
        mem_kabul_i = 1;
        tick();
        mem_kabul_i = 0; getir_iptal_i = 1;
        tick();
        getir_iptal_i = 0; getir_istek_i = 0; mem_gecerli_i = 1; mem_veri_i = 32'hAAAA5555;
        #1;
        toplam++; if ({getir_gecerli_o, vb_gecerli_o} !== 2'b00) $display("FAIL flush_bekle got=%b want=00", {getir_gecerli_o, vb_gecerli_o}); else gecen++;
        tick();
        mem_gecerli_i = 0;
        // Accept and flush in the same cycle: accept wins, response dropped.
        getir_istek_i = 1; getir_ps_i = 32'h308;
        tick();
        mem_kabul_i = 1; getir_iptal_i = 1;
        tick();
        mem_kabul_i = 0; getir_iptal_i = 0; getir_istek_i = 0;
        toplam++; if (mem_istek_o !== 1'b0) $display("FAIL flush_accept_wins got=%b want=0", mem_istek_o); else gecen++;
        mem_gecerli_i = 1; mem_veri_i = 32'h11112222;
        #1;
        toplam++; if (getir_gecerli_o !== 1'b0) $display("FAIL flush_accept_drop got=%b want=0", getir_gecerli_o); else gecen++;
        tick();
        mem_gecerli_i = 0;
        // Flush asserted throughout a load never disturbs it.
        vb_istek_i = 1; vb_yaz_i = 0; vb_adres_i = 32'h900;
        tick();
        getir_iptal_i = 1;
        tick();
        toplam++; if (mem_istek_o !== 1'b1 || mem_adres_o !== 32'h900) $display("FAIL flush_vb_hold got=%b/%h want=1/00000900", mem_istek_o, mem_adres_o); else gecen++;
        mem_kabul_i = 1;
        tick();
        mem_kabul_i = 0; mem_gecerli_i = 1; mem_veri_i = 32'h12345678;
        #1;
        toplam++; if (vb_gecerli_o !== 1'b1 || vb_veri_o !== 32'h12345678) $display("FAIL flush_vb_resp got=%b/%h want=1/12345678", vb_gecerli_o, vb_veri_o); else gecen++;
        tick();
        mem_gecerli_i = 0; vb_istek_i = 0; getir_iptal_i = 0;
        toplam++; if (hata_o !== 1'b0) $display("FAIL flush_no_hata got=%b want=0", hata_o); else gecen++;
        tick();
    endtask

    task automatic test_errors();
        mem_gecerli_i = 1; mem_veri_i = 32'hBAD0BAD0;
        #1;
        toplam++; if ({getir_gecerli_o, vb_gecerli_o} !== 2'b00) $display("FAIL err_ignored got=%b want=00", {getir_gecerli_o, vb_gecerli_o}); else gecen++;
        tick();
        mem_gecerli_i = 0;
        toplam++; if (hata_o !== 1'b1) $display("FAIL err_set got=%b want=1", hata_o); else gecen++;
        repeat (3) tick();
        toplam++; if (hata_o !== 1'b1) $display("FAIL err_sticky got=%b want=1", hata_o); else gecen++;
        // Reset in the middle of BEKLE.
        getir_istek_i = 1; getir_ps_i = 32'h500;
        tick();
        mem_kabul_i = 1;
        tick();
        mem_kabul_i = 0; getir_istek_i = 0; mem_veri_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        toplam++; if ({mem_istek_o, mem_yaz_o, mem_maske_o, mem_adres_o, mem_veri_o} !== 70'h0) $display("FAIL rst_mid_mem got=%b/%h/%h want=0", {mem_istek_o, mem_yaz_o, mem_maske_o}, mem_adres_o, mem_veri_o); else gecen++;
        toplam++; if ({hata_o, getir_gecerli_o, vb_gecerli_o} !== 3'b000) $display("FAIL rst_mid_flags got=%b want=000", {hata_o, getir_gecerli_o, vb_gecerli_o}); else gecen++;
        #2 rst_ni = 1'b1;
        tick();
        mem_gecerli_i = 1; mem_veri_i = 32'h0BADF00D;
        #1;
        toplam++; if (getir_gecerli_o !== 1'b0) $display("FAIL rst_late_resp got=%b want=0", getir_gecerli_o); else gecen++;
        tick();
        mem_gecerli_i = 0;
        toplam++; if (hata_o !== 1'b1) $display("FAIL rst_late_hata got=%b want=1", hata_o); else gecen++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_flush();
        test_errors();
        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule

// File: doc/bellek_hakemi.md
Name: bellek_hakemi

Overview:
- Arbitrates one shared instruction/data memory port between two requesters: the fetch stage (read-only) and the load/store unit (read/write).
- Sequences each transaction through a request/accept/response handshake, with one outstanding transaction at a time.
- Routes the response back to the requester that owns the transaction.
- Drops fetch responses made stale by a branch redirect. Sits between the fetch stage, the load/store unit and the memory/cache port.

Parameters:
- ADRES_W, 32, address width.
- VERI_W, 32, data width.
- MAX_ARDISIK, 4, maximum consecutive data-side grants while fetch waits; afterwards fetch wins (range 1..15).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- getir_istek_i  in  1  fetch read request; held with getir_ps_i stable until getir_gecerli_o or getir_iptal_i.
- getir_ps_i  in  ADRES_W  fetch address.
- getir_iptal_i  in  1  redirect/flush; cancels the pending fetch transaction.
- getir_gecerli_o  out  1  fetch response valid (1-cycle pulse).
- getir_deger_o  out  VERI_W  fetched instruction word.
- vb_istek_i  in  1  load/store request; held with its fields stable until vb_gecerli_o.
- vb_adres_i  in  ADRES_W  load/store address.
- vb_yaz_i  in  1  1 = store, 0 = load.
- vb_veri_i  in  VERI_W  store data.
- vb_maske_i  in  4  store byte enables.
- vb_gecerli_o  out  1  load data valid or store acknowledge (1-cycle pulse).
- vb_veri_o  out  VERI_W  load data.
- mem_istek_o  out  1  memory request, registered.
- mem_adres_o  out  ADRES_W  registered address.
- mem_yaz_o  out  1  registered write flag.
- mem_veri_o  out  VERI_W  registered write data.
- mem_maske_o  out  4  registered byte mask; 4'b0000 on reads.
- mem_kabul_i  in  1  memory accepts the request this cycle.
- mem_gecerli_i  in  1  memory response valid.
- mem_veri_i  in  VERI_W  memory read data.
- hata_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_ni=0):
  - State BOSTA; all mem_* outputs 0.
  - Starvation counter 0, sahip=GETIR, iptal bit 0, hata_o 0.
- States:
  - BOSTA → ISTEK: when either request is high; the winner is latched into the mem_* registers and sahip is set; mem_istek_o=1 from the next cycle.
  - ISTEK: hold mem_istek_o and all fields stable. If mem_kabul_i=1 → BEKLE, with mem_istek_o=0 next cycle.
  - BEKLE: wait for mem_gecerli_i. When it arrives → BOSTA.
- Arbitration in BOSTA:
  - Only one requester high → it wins.
  - Both high → vb wins, unless the counter equals MAX_ARDISIK, in which case getir wins.
  - Counter +1 on each vb grant taken while getir_istek_i=1.
  - Counter cleared on any getir grant, or on any cycle in BOSTA with getir_istek_i=0.
- Response routing (combinational, same cycle as mem_gecerli_i):
  - sahip=GETIR and iptal bit 0 → getir_gecerli_o=1, getir_deger_o=mem_veri_i.
  - sahip=VB → vb_gecerli_o=1, vb_veri_o=mem_veri_i (store ack also pulses).
  - When not valid, data outputs are don't-care and are driven with mem_veri_i.
- Latency:
  - Request seen in BOSTA at cycle t → mem_istek_o at t+1.
  - With mem_kabul_i at t+1 and mem_gecerli_i at t+2: response at t+2, BOSTA at t+3, next mem_istek_o at t+4.
  - A requester that keeps istek high at the cycle after its gecerli pulse is issuing a new request.
- Flush:
  - getir_iptal_i in BOSTA → fetch is excluded from arbitration that cycle.
  - In ISTEK with sahip=GETIR and mem_kabul_i=0 → withdraw: mem_istek_o=0 next cycle, go BOSTA, no response.
  - In ISTEK with mem_kabul_i=1 in the same cycle → the accept wins; go BEKLE with iptal bit set.
  - In BEKLE with sahip=GETIR → set iptal bit; the response is consumed silently, and the bit clears on return to BOSTA.
  - Flush never affects a vb transaction.
- Errors:
  - mem_gecerli_i in BOSTA or ISTEK sets hata_o.
  - hata_o stays set until reset; the response is ignored.
- Reset mid-transaction: immediately returns to the reset state; any later mem_gecerli_i for the aborted transaction sets hata_o.

Decomposition:
- Shared package holds:
  - State encoding (BOSTA=2'd0, ISTEK=2'd1, BEKLE=2'd2).
  - Owner encoding (SAHIP_GETIR=1'b0, SAHIP_VB=1'b1).
  - Default widths.
- Natural sub-module: bellek_hakemi_oncelik, the 2-way priority/starvation-counter arbiter (inputs: both requests, the iptal qualifier, grant-enable; outputs: one-hot grant). The FSM, datapath registers and response routing stay in the top module.

Test Plan:
1. Fetch only: getir_istek_i=1, ps=0x100; kabul at t+1; gecerli at t+2 with data 0x00000013 → mem_adres_o=0x100, mem_maske_o=0, getir_gecerli_o=1 with 0x00000013 at t+2, vb_gecerli_o=0.
2. Store: vb_yaz_i=1, adres 0x2000, veri 0xDEADBEEF, maske 4'b0011 → mem_yaz_o=1, mem_veri_o=0xDEADBEEF, mem_maske_o=4'b0011; ack pulses vb_gecerli_o only.
3. Both requesting continuously with MAX_ARDISIK=4 → grant sequence VB,VB,VB,VB,GETIR,VB…; counter cleared after the getir grant.
4. Flush: getir in ISTEK with kabul held 0 for 3 cycles, iptal at cycle 2 → mem_istek_o drops next cycle, no getir_gecerli_o; then flush in BEKLE → response 0xAAAA5555 discarded, no pulse; vb never affected.
5. Spurious mem_gecerli_i in BOSTA → hata_o=1 and stays set; rst_ni low mid-BEKLE → all outputs 0 asynchronously.
